// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared constants for the write-back stage
package writeback_stage_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// rtl/writeback_stage_load_formatter.sv - big-endian byte/halfword extract and extend
module load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // offset 0 addresses the most significant byte
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (size)
      LS_WORD: misaligned = (offset != 2'd0);
      LS_HALF: begin
        data       = load_unsigned ? {16'h0000, half_sel}
                                   : {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      LS_BYTE: begin
        data = load_unsigned ? {24'h000000, byte_sel}
                             : {{24{byte_sel[7]}}, byte_sel};
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, write-back select, write-once and forward register
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      valid_in,
  input  logic                      reg_write_in,
  input  logic                      mem_to_reg_in,
  input  logic [1:0]                load_size_in,
  input  logic                      load_unsigned_in,
  input  logic [1:0]                byte_offset_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  output logic                      reg_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [DATA_WIDTH-1:0]     write_back_data,
  output logic                      misaligned,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  logic                      valid_q;
  logic                      reg_write_q;
  logic                      mem_to_reg_q;
  logic [1:0]                load_size_q;
  logic                      load_unsigned_q;
  logic [1:0]                byte_offset_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     mem_q;
  logic                      written_q;

  logic [DATA_WIDTH-1:0]     load_data;
  logic                      load_misaligned;

  load_formatter u_load_formatter (
    .size          (load_size_q),
    .load_unsigned (load_unsigned_q),
    .offset        (byte_offset_q),
    .word          (mem_q),
    .data          (load_data),
    .misaligned    (load_misaligned)
  );

  assign misaligned       = valid_q & mem_to_reg_q & load_misaligned;
  assign rd_out           = rd_q;
  assign write_back_data  = mem_to_reg_q ? load_data : alu_q;
  assign reg_write_enable = valid_q & reg_write_q & (rd_q != '0) & ~misaligned & ~written_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      byte_offset_q   <= 2'b00;
      rd_q            <= '0;
      alu_q           <= '0;
      mem_q           <= '0;
      written_q       <= 1'b0;
    end else if (!stall) begin
      valid_q         <= valid_in;
      reg_write_q     <= reg_write_in;
      mem_to_reg_q    <= mem_to_reg_in;
      load_size_q     <= load_size_in;
      load_unsigned_q <= load_unsigned_in;
      byte_offset_q   <= byte_offset_in;
      rd_q            <= rd_in;
      alu_q           <= alu_result_in;
      mem_q           <= mem_data_in;
      written_q       <= 1'b0;
    end else if (reg_write_enable) begin
      // a held slot commits once; later stall cycles must not rewrite
      written_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= reg_write_enable;
      if (reg_write_enable) begin
        fwd_rd   <= rd_q;
        fwd_data <= write_back_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        valid_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  byte_offset_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_data_in;
  logic        reg_write_enable;
  logic [4:0]  rd_out;
  logic [31:0] write_back_data;
  logic        misaligned;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  writeback_stage dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .valid_in         (valid_in),
    .reg_write_in     (reg_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .byte_offset_in   (byte_offset_in),
    .rd_in            (rd_in),
    .alu_result_in    (alu_result_in),
    .mem_data_in      (mem_data_in),
    .reg_write_enable (reg_write_enable),
    .rd_out           (rd_out),
    .write_back_data  (write_back_data),
    .misaligned       (misaligned),
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                       input logic uns, input logic [1:0] off, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
    valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r; load_size_in = sz;
    load_unsigned_in = uns; byte_offset_in = off; rd_in = rd;
    alu_result_in = alu; mem_data_in = mem;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; idle();
    step(); step();
    checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", reg_write_enable); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd_out); end
    checks++; if (write_back_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", write_back_data); end
    checks++; if ({misaligned, fwd_valid} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {misaligned, fwd_valid}); end
    checks++; if ({fwd_rd, fwd_data} !== 37'h0) begin errors++; $display("FAIL reset_fwd got %h want 0", {fwd_rd, fwd_data}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd8, 32'h12345678, 32'hDEADBEEF);
    step();
    idle();
    checks++; if (reg_write_enable !== 1'b1) begin errors++; $display("FAIL alu_en got %b want 1", reg_write_enable); end
    checks++; if (rd_out !== 5'd8) begin errors++; $display("FAIL alu_rd got %0d want 8", rd_out); end
    checks++; if (write_back_data !== 32'h12345678) begin errors++; $display("FAIL alu_data got %h want 12345678", write_back_data); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL alu_fwd_early got %b want 0", fwd_valid); end
    step();
    checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid got %b want 1", fwd_valid); end
    checks++; if (fwd_rd !== 5'd8) begin errors++; $display("FAIL alu_fwd_rd got %0d want 8", fwd_rd); end
    checks++; if (fwd_data !== 32'h12345678) begin errors++; $display("FAIL alu_fwd_data got %h want 12345678", fwd_data); end
    checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL alu_en_after got %b want 0", reg_write_enable); end
    step();
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL alu_fwd_drop got %b want 0", fwd_valid); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    logic        uns [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  off [6] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h0000007F, 32'h000000FF,
                             32'h00007F01, 32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, sz[i], uns[i], off[i], 5'd9, 32'h11111111, 32'h80FF7F01);
      step();
      checks++; if (write_back_data !== exp[i]) begin errors++; $display("FAIL load%0d_data got %h want %h", i, write_back_data, exp[i]); end
      checks++; if ({reg_write_enable, misaligned} !== 2'b10) begin errors++; $display("FAIL load%0d_en_mis got %b want 10", i, {reg_write_enable, misaligned}); end
    end
    idle();
    step();
  endtask

  task automatic test_suppress();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'hCAFEF00D, 32'h0);
    step();
    checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL rd0_en got %b want 0", reg_write_enable); end
    checks++; if (write_back_data !== 32'hCAFEF00D) begin errors++; $display("FAIL rd0_data got %h want cafef00d", write_back_data); end
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 5'd10, 32'h0, 32'h01020304);
    step();
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rd0_fwd got %b want 0", fwd_valid); end
    checks++; if ({misaligned, reg_write_enable} !== 2'b10) begin errors++; $display("FAIL word_off1 got %b want 10", {misaligned, reg_write_enable}); end
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'd3, 5'd10, 32'h0, 32'h01020304);
    step();
    checks++; if ({misaligned, reg_write_enable} !== 2'b10) begin errors++; $display("FAIL half_off3 got %b want 10", {misaligned, reg_write_enable}); end
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 5'd10, 32'h0, 32'h01020304);
    step();
    checks++; if ({misaligned, reg_write_enable} !== 2'b10) begin errors++; $display("FAIL size_rsvd got %b want 10", {misaligned, reg_write_enable}); end
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'd1, 5'd10, 32'h0, 32'h01020304);
    step();
    checks++; if ({misaligned, reg_write_enable} !== 2'b00) begin errors++; $display("FAIL invalid_mis got %b want 00", {misaligned, reg_write_enable}); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL suppress_fwd got %b want 0", fwd_valid); end
    idle();
    step();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd5, 32'hA5A5A5A5, 32'h0);
    step();
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd12, 32'hBADBAD00, 32'h0);
    checks++; if (reg_write_enable !== 1'b1) begin errors++; $display("FAIL stall_c1_en got %b want 1", reg_write_enable); end
    step();
    checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL stall_c2_en got %b want 0", reg_write_enable); end
    checks++; if ({fwd_valid, fwd_rd} !== {1'b1, 5'd5}) begin errors++; $display("FAIL stall_fwd got %b/%0d want 1/5", fwd_valid, fwd_rd); end
    checks++; if ({rd_out, write_back_data} !== {5'd5, 32'hA5A5A5A5}) begin errors++; $display("FAIL stall_hold got %0d/%h want 5/a5a5a5a5", rd_out, write_back_data); end
    step();
    checks++; if ({reg_write_enable, fwd_valid} !== 2'b00) begin errors++; $display("FAIL stall_c3 got %b want 00", {reg_write_enable, fwd_valid}); end
    stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd6, 32'h00000066, 32'h0);
    step();
    idle();
    checks++; if ({reg_write_enable, rd_out} !== {1'b1, 5'd6}) begin errors++; $display("FAIL stall_next got %b/%0d want 1/6", reg_write_enable, rd_out); end
    checks++; if (write_back_data !== 32'h00000066) begin errors++; $display("FAIL stall_next_data got %h want 66", write_back_data); end
    step();
    checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd6, 32'h66}) begin errors++; $display("FAIL stall_next_fwd got %b/%0d/%h want 1/6/66", fwd_valid, fwd_rd, fwd_data); end
    step();
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd7, 32'h00000077, 32'h0);
    step();
    checks++; if (reg_write_enable !== 1'b1) begin errors++; $display("FAIL rst_pend_en got %b want 1", reg_write_enable); end
    stall = 1'b1; reset = 1'b1;
    step();
    checks++; if ({reg_write_enable, misaligned, fwd_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags got %b want 000", {reg_write_enable, misaligned, fwd_valid}); end
    checks++; if ({rd_out, write_back_data} !== 37'h0) begin errors++; $display("FAIL rst_mid_stage got %h want 0", {rd_out, write_back_data}); end
    checks++; if ({fwd_rd, fwd_data} !== 37'h0) begin errors++; $display("FAIL rst_mid_fwd got %h want 0", {fwd_rd, fwd_data}); end
    reset = 1'b0; stall = 1'b0; idle();
    step();
    checks++; if ({reg_write_enable, fwd_valid} !== 2'b00) begin errors++; $display("FAIL rst_after got %b want 00", {reg_write_enable, fwd_valid}); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd3, 32'h1, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 5'd4, 32'h2, 32'h0);
    checks++; if ({reg_write_enable, rd_out, write_back_data} !== {1'b1, 5'd3, 32'h1}) begin errors++; $display("FAIL b2b_first got %b/%0d/%h want 1/3/1", reg_write_enable, rd_out, write_back_data); end
    step();
    idle();
    checks++; if ({reg_write_enable, rd_out, write_back_data} !== {1'b1, 5'd4, 32'h2}) begin errors++; $display("FAIL b2b_second got %b/%0d/%h want 1/4/2", reg_write_enable, rd_out, write_back_data); end
    checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd3, 32'h1}) begin errors++; $display("FAIL b2b_fwd1 got %b/%0d/%h want 1/3/1", fwd_valid, fwd_rd, fwd_data); end
    step();
    checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd4, 32'h2}) begin errors++; $display("FAIL b2b_fwd2 got %b/%0d/%h want 1/4/2", fwd_valid, fwd_rd, fwd_data); end
    checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL b2b_en_end got %b want 0", reg_write_enable); end
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; idle();
    @(negedge clock);
    test_reset();
    test_alu_write();
    test_loads();
    test_suppress();
    test_stall();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
